id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with ALU-control decode, EX-stage
//               operand forwarding from EX/MEM and MEM/WB, operand-B select,
//               destination select and load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  id_alu_op,
    input  logic [5:0]  id_funct,
    input  logic [4:0]  id_shamt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [14:0] id_regs,
    input  logic [5:0]  id_ctrl,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_res,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic [2:0]  ALU_Ctr,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [4:0]  shamt,
    output logic [3:0]  ex_mem_ctrl,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dst_reg,
    output logic        load_use_stall
);

    // ALU operation encodings
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_nor = 3'b011;
    localparam logic [2:0] c_alu_srl = 3'b100;
    localparam logic [2:0] c_alu_sll = 3'b101;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_slt = 3'b111;

    // Control-vector bit positions: {reg_write, mem_to_reg, mem_read, mem_write, reg_dst, alu_src}
    localparam int c_ctrl_mem_read = 3;
    localparam int c_ctrl_reg_dst  = 1;
    localparam int c_ctrl_alu_src  = 0;

    // Stage register fields
    logic [2:0]  r_alu_ctr;
    logic [4:0]  r_shamt;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [5:0]  r_ctrl;

    logic [2:0]  w_alu_ctr;
    logic [4:0]  w_id_rs;
    logic [4:0]  w_id_rt;
    logic [4:0]  w_id_rd;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic        w_load_use;

    assign w_id_rs = id_regs[14:10];
    assign w_id_rt = id_regs[9:5];
    assign w_id_rd = id_regs[4:0];

    // Decode ALUOp/funct of the ID instruction into the ALU operation
    always_comb begin
        w_alu_ctr = c_alu_add;
        case (id_alu_op)
            2'b00: w_alu_ctr = c_alu_add;
            2'b01: w_alu_ctr = c_alu_sub;
            2'b11: w_alu_ctr = c_alu_or;
            default: begin
                case (id_funct)
                    6'b100000: w_alu_ctr = c_alu_add;
                    6'b100010: w_alu_ctr = c_alu_sub;
                    6'b100100: w_alu_ctr = c_alu_and;
                    6'b100101: w_alu_ctr = c_alu_or;
                    6'b100111: w_alu_ctr = c_alu_nor;
                    6'b101010: w_alu_ctr = c_alu_slt;
                    6'b000000: w_alu_ctr = c_alu_sll;
                    6'b000010: w_alu_ctr = c_alu_srl;
                    default:   w_alu_ctr = c_alu_add;
                endcase
            end
        endcase
    end

    // A load in EX whose target is read by the ID instruction must wait a cycle;
    // a flush squashes the ID instruction so no wait is needed then.
    assign w_load_use = r_ctrl[c_ctrl_mem_read] && (r_rt != 5'd0) &&
                        ((r_rt == w_id_rs) || (r_rt == w_id_rt)) && !flush;
    assign load_use_stall = w_load_use;

    // Stage register: reset > flush > stall > load-use bubble > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_ctr <= 3'd0;
            r_shamt   <= 5'd0;
            r_rs_data <= 32'd0;
            r_rt_data <= 32'd0;
            r_imm     <= 32'd0;
            r_rs      <= 5'd0;
            r_rt      <= 5'd0;
            r_rd      <= 5'd0;
            r_ctrl    <= 6'd0;
        end else if (flush || (!stall && w_load_use)) begin
            r_alu_ctr <= 3'd0;
            r_shamt   <= 5'd0;
            r_rs_data <= 32'd0;
            r_rt_data <= 32'd0;
            r_imm     <= 32'd0;
            r_rs      <= 5'd0;
            r_rt      <= 5'd0;
            r_rd      <= 5'd0;
            r_ctrl    <= 6'd0;
        end else if (!stall) begin
            r_alu_ctr <= w_alu_ctr;
            r_shamt   <= id_shamt;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_rs      <= w_id_rs;
            r_rt      <= w_id_rt;
            r_rd      <= w_id_rd;
            r_ctrl    <= id_ctrl;
        end
    end

    // Operand forwarding; the younger EX/MEM result takes precedence over MEM/WB
    always_comb begin
        w_fwd_a = r_rs_data;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rs)) begin
            w_fwd_a = exmem_res;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rs)) begin
            w_fwd_a = memwb_data;
        end

        w_fwd_b = r_rt_data;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rt)) begin
            w_fwd_b = exmem_res;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rt)) begin
            w_fwd_b = memwb_data;
        end
    end

    assign ALU_Ctr       = r_alu_ctr;
    assign A             = w_fwd_a;
    assign B             = r_ctrl[c_ctrl_alu_src] ? r_imm : w_fwd_b;
    assign shamt         = r_shamt;
    assign ex_mem_ctrl   = r_ctrl[5:2];
    assign ex_store_data = w_fwd_b;
    assign ex_dst_reg    = r_ctrl[c_ctrl_reg_dst] ? r_rd : r_rt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed, table-driven self-checking bench for id_ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [14:0] id_regs;
    logic [5:0]  id_ctrl;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_res;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic [2:0]  ALU_Ctr;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [3:0]  ex_mem_ctrl;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dst_reg;
    logic        load_use_stall;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .id_alu_op       (id_alu_op),
        .id_funct        (id_funct),
        .id_shamt        (id_shamt),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_regs         (id_regs),
        .id_ctrl         (id_ctrl),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_res       (exmem_res),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .ALU_Ctr         (ALU_Ctr),
        .A               (A),
        .B               (B),
        .shamt           (shamt),
        .ex_mem_ctrl     (ex_mem_ctrl),
        .ex_store_data   (ex_store_data),
        .ex_dst_reg      (ex_dst_reg),
        .load_use_stall  (load_use_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic [4:0]  sh;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic [14:0] regs;
        logic [5:0]  ctrl;
        logic [2:0]  e_alu;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [3:0]  e_mem;
        logic [4:0]  e_dst;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] alu, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh, input logic [3:0] mem,
                            input logic [31:0] st, input logic [4:0] dst, input logic lus);
        chk({tag, " ALU_Ctr"}, {29'd0, ALU_Ctr}, {29'd0, alu});
        chk({tag, " A"}, A, a);
        chk({tag, " B"}, B, b);
        chk({tag, " shamt"}, {27'd0, shamt}, {27'd0, sh});
        chk({tag, " ex_mem_ctrl"}, {28'd0, ex_mem_ctrl}, {28'd0, mem});
        chk({tag, " ex_store_data"}, ex_store_data, st);
        chk({tag, " ex_dst_reg"}, {27'd0, ex_dst_reg}, {27'd0, dst});
        chk({tag, " load_use_stall"}, {31'd0, load_use_stall}, {31'd0, lus});
    endtask

    task automatic drive_id(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                            input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] im,
                            input logic [14:0] rg, input logic [5:0] ct);
        id_alu_op  = op;
        id_funct   = fn;
        id_shamt   = sh;
        id_rs_data = rsd;
        id_rt_data = rtd;
        id_imm     = im;
        id_regs    = rg;
        id_ctrl    = ct;
    endtask

    localparam logic [14:0] c_r123 = {5'd1, 5'd2, 5'd3};

    initial begin
        // op, funct, shamt, rs_d, rt_d, imm, regs, ctrl, e_alu, e_a, e_b, e_mem, e_dst
        vecs[0]  = '{2'b10, 6'b100010, 5'd0,  32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00000010, c_r123, 6'b100010, 3'b110, 32'ha5a5a5a5, 32'h5a5a5a5a, 4'b1000, 5'd3};
        vecs[1]  = '{2'b00, 6'b000000, 5'd0,  32'h00001000, 32'h00002000, 32'h00000040, c_r123, 6'b110001, 3'b010, 32'h00001000, 32'h00000040, 4'b1100, 5'd2};
        vecs[2]  = '{2'b01, 6'b000000, 5'd0,  32'h00000007, 32'h00000009, 32'hfffffff0, c_r123, 6'b000000, 3'b110, 32'h00000007, 32'h00000009, 4'b0000, 5'd2};
        vecs[3]  = '{2'b11, 6'b000000, 5'd0,  32'hf0f0f0f0, 32'h0f0f0f0f, 32'h0000ffff, c_r123, 6'b100001, 3'b001, 32'hf0f0f0f0, 32'h0000ffff, 4'b1000, 5'd2};
        vecs[4]  = '{2'b10, 6'b100000, 5'd0,  32'h00000001, 32'h00000002, 32'h00000003, c_r123, 6'b100010, 3'b010, 32'h00000001, 32'h00000002, 4'b1000, 5'd3};
        vecs[5]  = '{2'b10, 6'b100100, 5'd0,  32'hffff0000, 32'h00ff00ff, 32'h00000000, c_r123, 6'b100010, 3'b000, 32'hffff0000, 32'h00ff00ff, 4'b1000, 5'd3};
        vecs[6]  = '{2'b10, 6'b100101, 5'd0,  32'h12345678, 32'h87654321, 32'h00000000, c_r123, 6'b100010, 3'b001, 32'h12345678, 32'h87654321, 4'b1000, 5'd3};
        vecs[7]  = '{2'b10, 6'b100111, 5'd0,  32'h00000000, 32'hffffffff, 32'h00000000, c_r123, 6'b100010, 3'b011, 32'h00000000, 32'hffffffff, 4'b1000, 5'd3};
        vecs[8]  = '{2'b10, 6'b101010, 5'd0,  32'h80000000, 32'h00000001, 32'h00000000, c_r123, 6'b100010, 3'b111, 32'h80000000, 32'h00000001, 4'b1000, 5'd3};
        vecs[9]  = '{2'b10, 6'b000000, 5'h0a, 32'h00000000, 32'h00000003, 32'h00000000, c_r123, 6'b100010, 3'b101, 32'h00000000, 32'h00000003, 4'b1000, 5'd3};
        vecs[10] = '{2'b10, 6'b000010, 5'h1f, 32'h00000000, 32'h80000000, 32'h00000000, c_r123, 6'b100010, 3'b100, 32'h00000000, 32'h80000000, 4'b1000, 5'd3};
        vecs[11] = '{2'b10, 6'b111111, 5'h04, 32'h00000005, 32'h00000006, 32'h00000000, c_r123, 6'b100010, 3'b010, 32'h00000005, 32'h00000006, 4'b1000, 5'd3};
        vecs[12] = '{2'b00, 6'b000000, 5'd0,  32'h00000100, 32'hcafef00d, 32'h00000008, c_r123, 6'b000101, 3'b010, 32'h00000100, 32'h00000008, 4'b0001, 5'd2};

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_id(2'b10, 6'b100010, 5'h11, 32'h11111111, 32'h22222222, 32'h33333333, c_r123, 6'b111111);
        exmem_reg_write = 1'b0;
        exmem_rd        = 5'd0;
        exmem_res       = 32'h0;
        memwb_reg_write = 1'b0;
        memwb_rd        = 5'd0;
        memwb_data      = 32'h0;

        // Reset state, with a clock edge occurring under reset
        #12;
        chk_outs("reset", 3'b000, 32'h0, 32'h0, 5'd0, 4'b0000, 32'h0, 5'd0, 1'b0);
        rst_n = 1'b1;

        // Table-driven decode / operand / control vectors
        for (int i = 0; i < 13; i++) begin
            drive_id(vecs[i].alu_op, vecs[i].funct, vecs[i].sh, vecs[i].rs_d, vecs[i].rt_d,
                     vecs[i].imm, vecs[i].regs, vecs[i].ctrl);
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_alu, vecs[i].e_a, vecs[i].e_b, vecs[i].sh,
                     vecs[i].e_mem, vecs[i].rt_d, vecs[i].e_dst, 1'b0);
        end

        // Forwarding priority with rs = rt = 3
        drive_id(2'b00, 6'b000000, 5'd0, 32'h00000111, 32'h00000222, 32'h0, {5'd3, 5'd3, 5'd4}, 6'b000000);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_res  = 32'h01234567;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_data = 32'h76543210;
        #1;
        chk("fwd exmem A", A, 32'h01234567);
        chk("fwd exmem B", B, 32'h01234567);
        chk("fwd exmem store", ex_store_data, 32'h01234567);
        exmem_reg_write = 1'b0;
        #1;
        chk("fwd memwb A", A, 32'h76543210);
        chk("fwd memwb B", B, 32'h76543210);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        chk("fwd rd0 A", A, 32'h00000111);
        chk("fwd rd0 B", B, 32'h00000222);
        exmem_reg_write = 1'b0;
        memwb_reg_write = 1'b0;

        // Load-use hazard: lw rt=5 in EX, ID instruction reads rs=5
        drive_id(2'b00, 6'b000000, 5'd0, 32'h0, 32'h0, 32'h4, {5'd1, 5'd5, 5'd0}, 6'b111001);
        tick();
        drive_id(2'b10, 6'b100000, 5'd0, 32'hdead0001, 32'hdead0002, 32'h0, {5'd5, 5'd7, 5'd9}, 6'b100010);
        #1;
        chk("load-use rs", {31'd0, load_use_stall}, 32'd1);
        flush = 1'b1;
        #1;
        chk("load-use masked by flush", {31'd0, load_use_stall}, 32'd0);
        flush = 1'b0;
        id_regs = {5'd7, 5'd5, 5'd9};
        #1;
        chk("load-use rt", {31'd0, load_use_stall}, 32'd1);
        id_regs = {5'd5, 5'd7, 5'd9};
        tick();
        chk_outs("bubble", 3'b000, 32'h0, 32'h0, 5'd0, 4'b0000, 32'h0, 5'd0, 1'b0);
        tick();
        chk_outs("after bubble", 3'b010, 32'hdead0001, 32'hdead0002, 5'd0, 4'b1000, 32'hdead0002, 5'd9, 1'b0);

        // Stall holds for three cycles while ID inputs change
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_id(2'b01, 6'b100111, 5'(c + 1), 32'(c + 100), 32'(c + 200), 32'(c + 300),
                     {5'd2, 5'd4, 5'd6}, 6'b011101);
            tick();
            chk_outs($sformatf("stall%0d", c), 3'b010, 32'hdead0001, 32'hdead0002, 5'd0, 4'b1000,
                     32'hdead0002, 5'd9, 1'b0);
        end
        flush = 1'b1;
        tick();
        chk_outs("flush+stall", 3'b000, 32'h0, 32'h0, 5'd0, 4'b0000, 32'h0, 5'd0, 1'b0);
        flush = 1'b0;
        stall = 1'b0;

        // SLL decode, then asynchronous reset mid-stall
        drive_id(2'b10, 6'b000000, 5'h0a, 32'h0, 32'h00000042, 32'h0, c_r123, 6'b100010);
        tick();
        chk_outs("sll", 3'b101, 32'h0, 32'h00000042, 5'h0a, 4'b1000, 32'h00000042, 5'd3, 1'b0);
        stall = 1'b1;
        tick();
        chk("sll held", {29'd0, ALU_Ctr}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async reset", 3'b000, 32'h0, 32'h0, 5'd0, 4'b0000, 32'h0, 5'd0, 1'b0);
        tick();
        chk_outs("reset held", 3'b000, 32'h0, 32'h0, 5'd0, 4'b0000, 32'h0, 5'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        stall = 1'b0;
        tick();
        chk_outs("post reset load", 3'b101, 32'h0, 32'h00000042, 5'h0a, 4'b1000, 32'h00000042, 5'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
